// File: rtl/wb_timeout_pkg.sv
// Shared definitions for the Wishbone bus watchdog: FSM state encoding and
// statistics counter width.
package wb_timeout_defs;

  localparam int STAT_WIDTH = 16;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_TERM    = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/wb_timeout.sv
// Wishbone classic bus watchdog. Passes master cycles straight through to the
// slave, and if a strobe waits TIMEOUT cycles without ack/err/rty it answers
// the master with a one-cycle error, blanks the slave strobe and swallows any
// late slave response until the master releases its strobe.
module wb_timeout
  import wb_timeout_defs::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int                    TIMEOUT      = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA     = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // master side
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  input  logic                    wbm_cyc_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  // slave side
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  // statistics
  input  logic                    stat_clear_i,
  output logic                    timeout_o,
  output logic [STAT_WIDTH-1:0]   timeout_count_o
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [STAT_WIDTH-1:0] evt_count_q;
  logic                  req, rsp, pass_thru;

  assign req = wbm_cyc_i & wbm_stb_i;
  assign rsp = wbs_ack_i | wbs_err_i | wbs_rty_i;

  // State and wait-counter registers.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and wait-counter logic; a response always beats the timeout.
  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req && !rsp) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (rsp) begin
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_TERM;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_TERM: begin
        state_d = ST_RECOVER;
        cnt_d   = '0;
      end
      ST_RECOVER: begin
        if (!wbm_stb_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus multiplexing: pass-through, error termination, or blanked recovery.
  always_comb begin
    pass_thru = (state_q == ST_IDLE) || (state_q == ST_WAIT) ||
                ((state_q == ST_RECOVER) && !wbm_stb_i);
    wbs_adr_o = wbm_adr_i;
    wbs_dat_o = wbm_dat_i;
    wbs_sel_o = wbm_sel_i;
    wbs_we_o  = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cyc_o = 1'b0;
    wbm_dat_o = ERR_DATA;
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    wbm_rty_o = 1'b0;
    timeout_o = 1'b0;
    // Reset gates the control strobes so nothing leaks out while rst_n is low.
    if (rst_n) begin
      if (pass_thru) begin
        wbs_we_o  = wbm_we_i;
        wbs_stb_o = wbm_stb_i;
        wbs_cyc_o = wbm_cyc_i;
        wbm_dat_o = wbs_dat_i;
        wbm_ack_o = wbs_ack_i;
        wbm_err_o = wbs_err_i;
        wbm_rty_o = wbs_rty_i;
      end
      if (state_q == ST_TERM) begin
        wbm_err_o = 1'b1;
        timeout_o = 1'b1;
      end
    end
  end

  // Saturating timeout event counter; a clear coinciding with TERM leaves 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_count_q <= '0;
    end else if (state_q == ST_TERM) begin
      if (stat_clear_i)                 evt_count_q <= STAT_WIDTH'(1);
      else if (evt_count_q != STAT_MAX) evt_count_q <= evt_count_q + STAT_WIDTH'(1);
    end else if (stat_clear_i) begin
      evt_count_q <= '0;
    end
  end

  assign timeout_count_o = evt_count_q;

endmodule
